load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter width_p, default 32, data/address width; only 32 is supported.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_i  input  1  reset; synchronous, active-high.
REQ-004 req_valid_i  input  1  memory operation request from the execute stage.
REQ-005 req_ready_o  output  1  unit accepts a request this cycle.
REQ-006 req_op_i  input  3  RV32I funct3: LB=000, LH=001, LW=010, LBU=100, LHU=101; stores SB=000, SH=001, SW=010.
REQ-007 req_is_store_i  input  1  1 = store, 0 = load.
REQ-008 req_addr_i  input  32  byte address.
REQ-009 req_wdata_i  input  32  store data, right-aligned.
REQ-010 req_rd_i  input  5  load destination register.
REQ-011 resp_valid_o  output  1  completion available.
REQ-012 resp_ready_i  input  1  writeback stage accepts completion.
REQ-013 resp_data_o  output  32  aligned, extended load result; 0 for stores.
REQ-014 resp_rd_o  output  5  destination register; resp_we_o output 1, register write enable (load, not misaligned, rd != 0).
REQ-015 resp_misaligned_o  output  1  access was misaligned; no memory access performed.
REQ-016 mem_addr_o output 32, mem_read_enable_o output 1, mem_write_enable_o output 1, mem_write_data_o output 32, mem_write_mask_o output 4: data memory request.
REQ-017 mem_read_data_i input 32, mem_busy_i input 1: data memory read data and busy.

Function
REQ-018 The FSM SHALL have states IDLE, MEM_REQ, MEM_WAIT and RESP; req_ready_o = (state == IDLE).
REQ-019 On req_valid_i && req_ready_o, op/addr/data/rd SHALL be registered; next state MEM_REQ, or RESP with misaligned = 1 when the access is misaligned.
REQ-020 Misaligned means halfword with addr[0] = 1, or word with addr[1:0] != 0.
REQ-021 In MEM_REQ exactly one of mem_read_enable_o/mem_write_enable_o SHALL be 1, for that single cycle only.
REQ-022 mem_addr_o SHALL hold the registered address in every non-IDLE state.
REQ-023 Store mask and data: SB mask = 1 << addr[1:0], data = byte replicated x4; SH mask = 0011 or 1100 per addr[1], data = halfword replicated x2; SW mask = 1111, data unchanged.
REQ-024 MEM_REQ: mem_busy_i = 0 and store -> RESP; mem_busy_i = 0 and load -> capture mem_read_data_i, RESP; otherwise -> MEM_WAIT.
REQ-025 MEM_WAIT: all enables 0; stay until mem_busy_i = 0, then capture mem_read_data_i for loads and go to RESP.
REQ-026 Load extraction: byte/halfword selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend; LW passes through.
REQ-027 RESP: resp_valid_o = 1 with all resp_* outputs stable until resp_ready_i = 1, then IDLE; no new request is accepted in that cycle.
REQ-028 Latency from accept cycle T: resp_valid_o at T+2 for full-word store, T+3 for load, T+5 for partial store, T+1 for misaligned.
REQ-029 Enable outputs SHALL be 0 in IDLE, MEM_WAIT and RESP.

Reset
REQ-030 While reset_i is sampled high the FSM SHALL go to IDLE and all registered fields SHALL clear to 0, including mid-operation; the unit does not issue or complete an abandoned request afterward.
REQ-031 After reset: req_ready_o = 1; resp_valid_o, resp_we_o, resp_misaligned_o and the enables = 0; mem_* data/mask/addr = 0.

Structure
REQ-032 Package lsu_pkg SHALL hold the funct3 op enum (mem_op_t), the FSM state typedef lsu_state_t, and the mask constants.
REQ-033 Load extraction/extension SHALL be a combinational sub-module named lsu_load_align (inputs rdata, addr[1:0], op; output 32-bit result).

Verification
REQ-034 SW 0xDEADBEEF to 0x10, then LW 0x10 -> store resp at T+2; load resp_data_o = 0xDEADBEEF at T+3, resp_we_o = 1.
REQ-035 SB 0x000000A5 to 0x13 over 0x11223344 -> mask 1000, wdata 0xA5A5A5A5, resp at T+5; LW 0x10 returns 0xA5223344.
REQ-036 Word 0x80FF7F01 at 0x20: LB 0x23 -> 0xFFFFFF80; LBU 0x23 -> 0x00000080; LH 0x22 -> 0xFFFF80FF; LHU 0x20 -> 0x00007F01.
REQ-037 LW 0x22 and SH 0x21 -> resp_misaligned_o = 1 at T+1; no mem enable is ever asserted.
REQ-038 Load response held with resp_ready_i = 0 for 3 cycles -> outputs stable, req_ready_o = 0; release -> IDLE the next cycle.
REQ-039 reset_i asserted in MEM_WAIT of a partial store -> IDLE, outputs are the reset values, and no later resp_valid_o occurs.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 op encoding, FSM
// states, store byte-lane masks and the store formatting rules.
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_B  = 3'b000,
        OP_H  = 3'b001,
        OP_W  = 3'b010,
        OP_BU = 3'b100,
        OP_HU = 3'b101
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE,
        MEM_REQ,
        MEM_WAIT,
        RESP
    } lsu_state_t;

    localparam logic [3:0] MASK_NONE    = 4'b0000;
    localparam logic [3:0] MASK_BYTE0   = 4'b0001;
    localparam logic [3:0] MASK_HALF_LO = 4'b0011;
    localparam logic [3:0] MASK_HALF_HI = 4'b1100;
    localparam logic [3:0] MASK_WORD    = 4'b1111;

    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] addr);
        case (op)
            OP_H, OP_HU: is_misaligned = addr[0];
            OP_W:        is_misaligned = (addr != 2'b00);
            default:     is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input mem_op_t op, input logic [1:0] addr);
        case (op)
            OP_B:    store_mask = MASK_BYTE0 << addr;
            OP_H:    store_mask = addr[1] ? MASK_HALF_HI : MASK_HALF_LO;
            default: store_mask = MASK_WORD;
        endcase
    endfunction

    // Narrow store data is replicated across all lanes; the mask picks the live one.
    function automatic logic [31:0] store_data(input mem_op_t op, input logic [31:0] wdata);
        case (op)
            OP_B:    store_data = {4{wdata[7:0]}};
            OP_H:    store_data = {2{wdata[15:0]}};
            default: store_data = wdata;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Combinational load-data extraction: selects the addressed byte/halfword of
// the read word and sign- or zero-extends it according to the funct3 op.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  mem_op_t     op,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (op)
            OP_B:    result = {{24{byte_sel[7]}}, byte_sel};
            OP_BU:   result = {24'd0, byte_sel};
            OP_H:    result = {{16{half_sel[15]}}, half_sel};
            OP_HU:   result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: registers one request, issues a one-cycle
// data memory access, waits out mem_busy_i and holds the completion until taken.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [2:0]         req_op_i,
    input  logic               req_is_store_i,
    input  logic [width_p-1:0] req_addr_i,
    input  logic [width_p-1:0] req_wdata_i,
    input  logic [4:0]         req_rd_i,
    output logic               resp_valid_o,
    input  logic               resp_ready_i,
    output logic [width_p-1:0] resp_data_o,
    output logic [4:0]         resp_rd_o,
    output logic               resp_we_o,
    output logic               resp_misaligned_o,
    output logic [width_p-1:0] mem_addr_o,
    output logic               mem_read_enable_o,
    output logic               mem_write_enable_o,
    output logic [width_p-1:0] mem_write_data_o,
    output logic [3:0]         mem_write_mask_o,
    input  logic [width_p-1:0] mem_read_data_i,
    input  logic               mem_busy_i
);

    lsu_state_t         state_q, state_d;
    mem_op_t            op_q, op_in;
    logic               is_store_q;
    logic               misaligned_q;
    logic [width_p-1:0] addr_q;
    logic [width_p-1:0] wdata_q;
    logic [3:0]         mask_q;
    logic [4:0]         rd_q;
    logic [width_p-1:0] rdata_q;
    logic [width_p-1:0] load_result;
    logic               accept;
    logic               mis_in;
    logic               capture;

    assign op_in  = mem_op_t'(req_op_i);
    assign accept = req_valid_i && req_ready_o;
    assign mis_in = is_misaligned(op_in, req_addr_i[1:0]);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            op_q         <= OP_B;
            is_store_q   <= 1'b0;
            misaligned_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mask_q       <= MASK_NONE;
            rd_q         <= '0;
            rdata_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q         <= op_in;
                is_store_q   <= req_is_store_i;
                misaligned_q <= mis_in;
                addr_q       <= req_addr_i;
                rd_q         <= req_rd_i;
                // Lane formatting is done at accept so mask/data are plain registers.
                if (req_is_store_i && !mis_in) begin
                    mask_q  <= store_mask(op_in, req_addr_i[1:0]);
                    wdata_q <= store_data(op_in, req_wdata_i);
                end else begin
                    mask_q  <= MASK_NONE;
                    wdata_q <= '0;
                end
            end
            if (capture) begin
                rdata_q <= mem_read_data_i;
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        mem_read_enable_o  = 1'b0;
        mem_write_enable_o = 1'b0;
        capture            = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = mis_in ? RESP : MEM_REQ;
                end
            end
            MEM_REQ: begin
                mem_read_enable_o  = !is_store_q;
                mem_write_enable_o = is_store_q;
                if (!mem_busy_i) begin
                    capture = !is_store_q;
                    state_d = RESP;
                end else begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (!mem_busy_i) begin
                    capture = !is_store_q;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    lsu_load_align u_load_align (
        .rdata  (rdata_q),
        .addr   (addr_q[1:0]),
        .op     (op_q),
        .result (load_result)
    );

    assign req_ready_o       = (state_q == IDLE);
    assign resp_valid_o      = (state_q == RESP);
    assign resp_data_o       = (is_store_q || misaligned_q) ? '0 : load_result;
    assign resp_rd_o         = rd_q;
    assign resp_we_o         = resp_valid_o && !is_store_q && !misaligned_q && (rd_q != 5'd0);
    assign resp_misaligned_o = resp_valid_o && misaligned_q;
    assign mem_addr_o        = addr_q;
    assign mem_write_data_o  = wdata_q;
    assign mem_write_mask_o  = mask_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// traffic against a byte-array reference memory and a busy-stretching memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  req_op_i;
    logic        req_is_store_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [4:0]  req_rd_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_data_o;
    logic [4:0]  resp_rd_o;
    logic        resp_we_o;
    logic        resp_misaligned_o;
    logic [31:0] mem_addr_o;
    logic        mem_read_enable_o;
    logic        mem_write_enable_o;
    logic [31:0] mem_write_data_o;
    logic [3:0]  mem_write_mask_o;
    logic [31:0] mem_read_data_i;
    logic        mem_busy_i;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.width_p(32)) dut (
        .clk_i              (clk),
        .reset_i            (reset_i),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_op_i           (req_op_i),
        .req_is_store_i     (req_is_store_i),
        .req_addr_i         (req_addr_i),
        .req_wdata_i        (req_wdata_i),
        .req_rd_i           (req_rd_i),
        .resp_valid_o       (resp_valid_o),
        .resp_ready_i       (resp_ready_i),
        .resp_data_o        (resp_data_o),
        .resp_rd_o          (resp_rd_o),
        .resp_we_o          (resp_we_o),
        .resp_misaligned_o  (resp_misaligned_o),
        .mem_addr_o         (mem_addr_o),
        .mem_read_enable_o  (mem_read_enable_o),
        .mem_write_enable_o (mem_write_enable_o),
        .mem_write_data_o   (mem_write_data_o),
        .mem_write_mask_o   (mem_write_mask_o),
        .mem_read_data_i    (mem_read_data_i),
        .mem_busy_i         (mem_busy_i)
    );

    // Data memory model: reads return data one cycle after the request (busy
    // during the request cycle); partial writes stay busy two further cycles.
    logic [31:0] mem_words [0:63];
    logic [7:0]  ref_mem   [0:255];
    int unsigned busy_extra = 0;
    int unsigned busy_cnt   = 0;
    int unsigned en_total   = 0;
    int unsigned both_en    = 0;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_wmask;

    assign mem_busy_i = (busy_cnt != 0) || mem_read_enable_o
                     || (mem_write_enable_o && mem_write_mask_o != 4'hF)
                     || ((mem_read_enable_o || mem_write_enable_o) && busy_extra != 0);

    always @(posedge clk) begin
        if (mem_read_enable_o && mem_write_enable_o) both_en <= both_en + 1;
        if (mem_read_enable_o || mem_write_enable_o) begin
            en_total  <= en_total + 1;
            last_addr <= mem_addr_o;
            busy_cnt  <= ((mem_write_enable_o && mem_write_mask_o != 4'hF) ? 2 : 0) + busy_extra;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (mem_read_enable_o) mem_read_data_i <= mem_words[mem_addr_o[7:2]];
        if (mem_write_enable_o) begin
            last_wdata <= mem_write_data_o;
            last_wmask <= mem_write_mask_o;
            for (int b = 0; b < 4; b++)
                if (mem_write_mask_o[b])
                    mem_words[mem_addr_o[7:2]][8*b +: 8] <= mem_write_data_o[8*b +: 8];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ready"}, req_ready_o, 1);
        check_eq({tag, "_resp"}, {resp_valid_o, resp_we_o, resp_misaligned_o}, 0);
        check_eq({tag, "_en"}, {mem_read_enable_o, mem_write_enable_o}, 0);
        check_eq({tag, "_mem"}, {mem_addr_o, mem_write_mask_o}, 0);
        check_eq({tag, "_wdata"}, mem_write_data_o, 0);
    endtask

    task automatic do_txn(input logic st, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd,
                          input int unsigned extra, input int unsigned hold);
        int unsigned size, lat, en_before, exp_lat, wait_cnt;
        logic        mis;
        logic [31:0] exp_data, exp_wd;
        logic [3:0]  exp_mask;
        logic [40:0] snap;

        size = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
        mis  = (addr % size) != 0;
        exp_data = 0;
        exp_wd   = 0;
        exp_mask = 0;
        if (!st && !mis) begin
            for (int i = 0; i < int'(size); i++) exp_data |= 32'(ref_mem[addr + i]) << (8 * i);
            if (!op[2] && size < 4 && exp_data[8*size-1]) exp_data |= ~((32'd1 << (8 * size)) - 1);
        end
        if (st && !mis) begin
            exp_mask = 4'(((1 << size) - 1) << (addr % 4));
            for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = wd[8*(j % int'(size)) +: 8];
            for (int i = 0; i < int'(size); i++) ref_mem[addr + i] = wd[8*i +: 8];
        end
        exp_lat = mis ? 1 : (st ? (size == 4 ? 2 : 5) : 3);

        busy_extra = extra;
        en_before  = en_total;
        wait_cnt   = 0;
        while (!req_ready_o && wait_cnt < 20) begin @(negedge clk); wait_cnt++; end
        req_valid_i = 1; req_is_store_i = st; req_op_i = op;
        req_addr_i = addr; req_wdata_i = wd; req_rd_i = rd;
        @(negedge clk);
        req_valid_i = 0;
        lat = 1;
        while (!resp_valid_o && lat < 100) begin @(negedge clk); lat++; end
        if (!resp_valid_o) begin
            check_eq("resp_timeout", 0, 1);
            return;
        end
        if (extra == 0) check_eq("latency", lat, exp_lat);
        check_eq("resp_data", resp_data_o, exp_data);
        check_eq("resp_rd", resp_rd_o, rd);
        check_eq("resp_we", resp_we_o, !st && !mis && rd != 0);
        check_eq("resp_mis", resp_misaligned_o, mis);
        check_eq("en_cycles", en_total - en_before, mis ? 0 : 1);
        if (!mis) check_eq("mem_addr", last_addr, addr);
        if (st && !mis) check_eq("wmask_wdata", {last_wmask, last_wdata}, {exp_mask, exp_wd});
        snap = {resp_valid_o, resp_data_o, resp_rd_o, resp_we_o, resp_misaligned_o, req_ready_o};
        for (int h = 0; h < int'(hold); h++) begin
            @(negedge clk);
            check_eq("hold_stable",
                     {resp_valid_o, resp_data_o, resp_rd_o, resp_we_o, resp_misaligned_o, req_ready_o}, snap);
        end
        resp_ready_i = 1;
        @(negedge clk);
        resp_ready_i = 0;
        check_eq("back_idle", {req_ready_o, resp_valid_o}, 2'b10);
        check_eq("no_extra_en", en_total - en_before, mis ? 0 : 1);
    endtask

    initial begin
        int unsigned seen;
        logic [2:0] rop;
        logic       rst;
        reset_i = 1; req_valid_i = 0; resp_ready_i = 0;
        req_op_i = 0; req_is_store_i = 0; req_addr_i = 0; req_wdata_i = 0; req_rd_i = 0;
        for (int w = 0; w < 64; w++) begin
            mem_words[w] = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*w + b] = mem_words[w][8*b +: 8];
        end
        repeat (2) @(negedge clk);
        reset_i = 0;
        check_idle_outputs("reset");
        check_eq("both_en", both_en, 0);

        do_txn(1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0, 0, 0);
        do_txn(0, 3'b010, 32'h10, 32'h0, 5'd7, 0, 0);
        do_txn(1, 3'b010, 32'h10, 32'h11223344, 5'd0, 0, 0);
        do_txn(1, 3'b000, 32'h13, 32'h000000A5, 5'd0, 0, 0);
        do_txn(0, 3'b010, 32'h10, 32'h0, 5'd3, 0, 0);
        do_txn(1, 3'b010, 32'h20, 32'h80FF7F01, 5'd0, 0, 0);
        do_txn(0, 3'b000, 32'h23, 32'h0, 5'd1, 0, 0);
        do_txn(0, 3'b100, 32'h23, 32'h0, 5'd2, 0, 0);
        do_txn(0, 3'b001, 32'h22, 32'h0, 5'd4, 0, 0);
        do_txn(0, 3'b101, 32'h20, 32'h0, 5'd5, 0, 0);
        do_txn(0, 3'b010, 32'h22, 32'h0, 5'd6, 0, 0);
        do_txn(1, 3'b001, 32'h21, 32'h1234, 5'd0, 0, 0);
        do_txn(0, 3'b010, 32'h20, 32'h0, 5'd9, 0, 3);
        do_txn(0, 3'b010, 32'h20, 32'h0, 5'd0, 0, 1);

        // Reset while a partial store sits in MEM_WAIT; the write already happened.
        req_valid_i = 1; req_is_store_i = 1; req_op_i = 3'b001;
        req_addr_i = 32'h42; req_wdata_i = 32'h0000BEEF; req_rd_i = 0;
        @(negedge clk);
        req_valid_i = 0;
        ref_mem[8'h42] = 8'hEF; ref_mem[8'h43] = 8'hBE;
        repeat (2) @(negedge clk);
        check_eq("pre_reset_busy", {req_ready_o, resp_valid_o}, 0);
        reset_i = 1;
        @(negedge clk);
        reset_i = 0;
        check_idle_outputs("midreset");
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (resp_valid_o) seen++;
        end
        check_eq("no_resp_after_reset", seen, 0);
        do_txn(0, 3'b101, 32'h42, 32'h0, 5'd8, 0, 0);

        for (int n = 0; n < 200; n++) begin
            rst = 1'($urandom_range(0, 1));
            if (rst) rop = 3'($urandom_range(0, 2));
            else begin
                rop = 3'($urandom_range(0, 4));
                if (rop == 3'd3) rop = 3'd5;
            end
            do_txn(rst, rop, 32'($urandom_range(0, 255)), $urandom, 5'($urandom),
                   $urandom_range(0, 2), $urandom_range(0, 2));
        end
        check_eq("both_en_final", both_en, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
